alu_ctrl_mdu: RTL and testbench
===============================

// Module: alu_ctrl_mdu
// PURPOSE
//  Second-generation ALU control for the MIPS datapath: decodes ALUOp/funct into the 4-bit ALU select,
//  registered for a one-cycle pipeline stage. Adds the multiply/divide unit (MDU): iterative MULT/MULTU/DIV/DIVU
//  into HI/LO, MFHI/MFLO/MTHI/MTLO access, and a stall output to the hazard unit while the MDU is busy.
// PARAMETERS
//  WIDTH    32  datapath / operand width (>=4)
//  OPW      4   ALU select width
//  CNT_W    6   iteration counter width, >= clog2(WIDTH+1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  valid_i     in   1      instruction present this cycle
//  flush_i     in   1      squash: abort in-flight MDU op, drop current instruction
//  alu_op_i    in   2      main-control ALUOp
//  funct_i     in   6      instruction funct field
//  rs_val_i    in   WIDTH  rs operand (dividend / multiplicand / MT source)
//  rt_val_i    in   WIDTH  rt operand (divisor / multiplier)
//  stall_o     out  1      comb: valid_i & busy & HI/LO-class funct; instruction not accepted
//  alu_sel_o   out  OPW    registered ALU select
//  sel_vld_o   out  1      registered: alu_sel_o belongs to an accepted instruction
//  hilo_rd_o   out  WIDTH  registered MFHI/MFLO result
//  hilo_vld_o  out  1      registered: hilo_rd_o valid (one cycle)
//  busy_o      out  1      MDU operation in flight
//  hi_o, lo_o  out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  - Reset: all outputs 0 except alu_sel_o = 4'b1111; FSM IDLE; HI = LO = 0.
//  - accept = valid_i & ~stall_o & ~flush_i. Outputs update at the edge after accept (latency 1).
//  - Decode: ALUOp 00 -> 0010 (add), 01 -> 0110 (sub), 11 -> 1111.
//    ALUOp 10: funct 100000 -> 0010, 100010 -> 0110, 101010 -> 0111, 100100 -> 0000,
//    100101 -> 0001, 100111 -> 1100 (nor), 000000 -> 1111, all others -> 1111.
//  - HI/LO-class funct (ALUOp 10 only): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU,
//    010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO. The ALU select for these is 1111.
//  - Non-HI/LO instructions are accepted while busy; only the HI/LO class stalls.
//  - MF*: hilo_rd_o <= HI or LO, hilo_vld_o pulses 1 cycle. MT*: HI or LO <= rs_val_i at the accept edge.
//  - FSM: IDLE -> MUL | DIV on an accepted mult/div op, latching operands (abs values and sign flags if signed).
//    MUL/DIV run WIDTH iterations (shift-add / restoring), then FIX, then IDLE.
//    FIX applies sign correction and writes HI and LO together.
//    busy_o is high from the edge after accept through the FIX cycle: WIDTH+1 cycles total.
//  - Signed results: quotient negated if operand signs differ; remainder takes the dividend's sign.
//    Product is 2*WIDTH bits, HI = upper half.
//  - Divide by zero: no trap. LO = all ones, HI = rs_val (signed: same rule on magnitudes, then sign fix).
//    Signed MIN / -1: LO = MIN, HI = 0.
//  - flush_i while busy: FSM returns to IDLE next edge, HI/LO unchanged, busy_o drops.
//    flush_i together with a start: flush wins, no start.
//  - FIX cycle with a simultaneous stalled MF*: the stall holds through FIX.
//    The MF* is accepted the cycle after and reads the new HI/LO.
//  - Reset mid-operation: immediate IDLE, HI/LO cleared, no partial write.
// STRUCTURE
//  - Package alu_ctrl_pkg: ALU select constants (ALU_AND/OR/ADD/SUB/SLT/NOR/NOP),
//    ALUOp codes, funct codes, MDU state encoding.
//  - One sub-module: mdu_iter (iterative multiply/divide datapath with counter and FIX sign logic).
//    The top level holds the decode, handshake and HI/LO registers.
// TESTING
//  1 ALUOp 10, each funct (add/sub/slt/and/or/nor/nop/illegal 111111)
//    -> alu_sel_o = 0010/0110/0111/0000/0001/1100/1111/1111 one cycle later, sel_vld_o = 1.
//  2 MULT rs = -3, rt = 7 -> busy 33 cycles (WIDTH = 32), then HI = FFFFFFFF, LO = FFFFFFEB.
//    MULTU FFFFFFFF * 2 -> HI = 1, LO = FFFFFFFE.
//  3 DIV rs = -7, rt = 2 -> LO = FFFFFFFD, HI = FFFFFFFF.
//    DIVU by 0 with rs = 5 -> LO = FFFFFFFF, HI = 5.
//    DIV 80000000 / FFFFFFFF -> LO = 80000000, HI = 0.
//  4 MFLO issued 3 cycles after MULT -> stall_o high until busy_o falls, then hilo_vld_o with the new LO.
//    An ADD issued mid-op is not stalled.
//  5 flush_i at iteration 10 of DIV -> busy_o low next cycle, HI/LO keep prior values.
//    MTHI AAAA5555 then MFHI -> hilo_rd_o = AAAA5555.
//  6 rst_n low mid-MULT -> all outputs at reset values asynchronously.
//    After release, MFHI returns 0.

Source files
------------

// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared constants for the ALU control / multiply-divide unit: ALU select
// codes, ALUOp codes, funct codes, MDU state encoding and the ALU decode.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_NOP   = 2'b11;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_MUL  = 2'b01,
      MDU_DIV  = 2'b10,
      MDU_FIX  = 2'b11
   } mdu_state_e;

   // HI/LO-class instructions all drive the ALU with the no-op select.
   function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                             input logic [5:0] funct);
      logic [3:0] sel;
      sel = ALU_NOP;
      case (alu_op)
         ALUOP_ADD: sel = ALU_ADD;
         ALUOP_SUB: sel = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               F_ADD:   sel = ALU_ADD;
               F_SUB:   sel = ALU_SUB;
               F_SLT:   sel = ALU_SLT;
               F_AND:   sel = ALU_AND;
               F_OR:    sel = ALU_OR;
               F_NOR:   sel = ALU_NOR;
               default: sel = ALU_NOP;
            endcase
         end
         default: sel = ALU_NOP;
      endcase
      return sel;
   endfunction

   function automatic logic is_hilo_funct(input logic [5:0] funct);
      return (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV)  ||
             (funct == F_DIVU) || (funct == F_MFHI)  || (funct == F_MFLO) ||
             (funct == F_MTHI) || (funct == F_MTLO);
   endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Iterative multiply/divide datapath: one bit per cycle (shift-add multiply,
// restoring divide) on operand magnitudes, followed by a single sign-fix cycle.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  MDU_IDLE | waiting for start_i; operands latched on start
//  MDU_MUL  | WIDTH shift-add iterations, counter counts down to 1
//  MDU_DIV  | WIDTH restoring-divide iterations, counter counts down to 1
//  MDU_FIX  | sign correction; done_o tells the top to write HI and LO
module mdu_iter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_res_o,
   output logic [WIDTH-1:0] lo_res_o
);

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;     // product upper half / partial remainder
   logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand / divisor magnitude
   logic               neg_q, neg_d;     // negate product or quotient
   logic               rneg_q, rneg_d;   // negate remainder (dividend was negative)
   logic               div_q, div_d;

   logic [WIDTH-1:0]   a_mag, b_mag, addend, div_sub;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_fits;
   logic [2*WIDTH-1:0] prod_mag, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Next-state, counter and datapath step for the iterative engine.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      opd_d     = opd_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      div_d     = div_q;

      a_mag     = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      b_mag     = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      addend    = lo_q[0] ? opd_q : '0;
      mul_sum   = {1'b0, acc_q} + {1'b0, addend};
      div_shift = {acc_q, lo_q[WIDTH-1]};
      div_fits  = (div_shift >= {1'b0, opd_q});
      div_sub   = div_shift[WIDTH-1:0] - opd_q;

      case (state_q)
         MDU_IDLE: begin
            if (start_i) begin
               state_d = is_div_i ? MDU_DIV : MDU_MUL;
               cnt_d   = CNT_W'(WIDTH);
               acc_d   = '0;
               lo_d    = is_div_i ? a_mag : b_mag;
               opd_d   = is_div_i ? b_mag : a_mag;
               neg_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               rneg_d  = is_signed_i & a_i[WIDTH-1];
               div_d   = is_div_i;
            end
         end
         MDU_MUL: begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = MDU_FIX;
         end
         MDU_DIV: begin
            acc_d = div_fits ? div_sub : div_shift[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], div_fits};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = MDU_FIX;
         end
         default: state_d = MDU_IDLE;
      endcase

      // A squash abandons the operation without touching HI/LO.
      if (flush_i && (state_q != MDU_IDLE)) state_d = MDU_IDLE;
   end

   // Engine registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opd_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opd_q   <= opd_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div_q   <= div_d;
      end
   end

   // Sign fix on the magnitude results; only consumed while in MDU_FIX.
   always_comb begin
      prod_mag = {acc_q, lo_q};
      prod_fix = neg_q ? -prod_mag : prod_mag;
      quo_fix  = neg_q ? -lo_q : lo_q;
      rem_fix  = rneg_q ? -acc_q : acc_q;
      hi_res_o = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      lo_res_o = div_q ? quo_fix : prod_fix[WIDTH-1:0];
   end

   assign busy_o = (state_q != MDU_IDLE);
   assign done_o = (state_q == MDU_FIX) & ~flush_i;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control with multiply/divide unit: registered ALU select decode,
// accept/stall handshake for HI/LO-class instructions, and HI/LO registers.
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             flush_i,
   input  logic [1:0]       alu_op_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] rs_val_i,
   input  logic [WIDTH-1:0] rt_val_i,
   output logic             stall_o,
   output logic [OPW-1:0]   alu_sel_o,
   output logic             sel_vld_o,
   output logic [WIDTH-1:0] hilo_rd_o,
   output logic             hilo_vld_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic             is_rtype, hilo_cls, is_muldiv, is_mf, is_mt, accept;
   logic             mdu_busy, mdu_done, mdu_start, mdu_div, mdu_signed;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;

   logic [OPW-1:0]   alu_sel_q, alu_sel_d;
   logic             sel_vld_q, sel_vld_d;
   logic [WIDTH-1:0] hilo_rd_q, hilo_rd_d;
   logic             hilo_vld_q, hilo_vld_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Instruction classification and handshake.
   always_comb begin
      is_rtype   = (alu_op_i == ALUOP_RTYPE);
      hilo_cls   = is_rtype & is_hilo_funct(funct_i);
      is_muldiv  = is_rtype & ((funct_i == F_MULT) || (funct_i == F_MULTU) ||
                               (funct_i == F_DIV)  || (funct_i == F_DIVU));
      is_mf      = is_rtype & ((funct_i == F_MFHI) || (funct_i == F_MFLO));
      is_mt      = is_rtype & ((funct_i == F_MTHI) || (funct_i == F_MTLO));
      stall_o    = valid_i & mdu_busy & hilo_cls;
      accept     = valid_i & ~stall_o & ~flush_i;
      mdu_start  = accept & is_muldiv;
      mdu_div    = funct_i[1];
      mdu_signed = ~funct_i[0];
   end

   mdu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mdu_iter (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (mdu_start),
      .is_div_i    (mdu_div),
      .is_signed_i (mdu_signed),
      .flush_i     (flush_i),
      .a_i         (rs_val_i),
      .b_i         (rt_val_i),
      .busy_o      (mdu_busy),
      .done_o      (mdu_done),
      .hi_res_o    (mdu_hi),
      .lo_res_o    (mdu_lo)
   );

   // Next values for the pipeline outputs and HI/LO. MT*/MF* can never
   // coincide with mdu_done because they stall while the MDU is busy.
   always_comb begin
      alu_sel_d  = alu_sel_q;
      sel_vld_d  = accept;
      hilo_rd_d  = hilo_rd_q;
      hilo_vld_d = accept & is_mf;
      hi_d       = hi_q;
      lo_d       = lo_q;
      if (accept) alu_sel_d = OPW'(alu_decode(alu_op_i, funct_i));
      if (accept && is_mf) hilo_rd_d = (funct_i == F_MFHI) ? hi_q : lo_q;
      if (accept && is_mt) begin
         if (funct_i == F_MTHI) hi_d = rs_val_i;
         else                   lo_d = rs_val_i;
      end
      if (mdu_done) begin
         hi_d = mdu_hi;
         lo_d = mdu_lo;
      end
   end

   // Output and architectural registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_sel_q  <= '1;
         sel_vld_q  <= 1'b0;
         hilo_rd_q  <= '0;
         hilo_vld_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         alu_sel_q  <= alu_sel_d;
         sel_vld_q  <= sel_vld_d;
         hilo_rd_q  <= hilo_rd_d;
         hilo_vld_q <= hilo_vld_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign alu_sel_o  = alu_sel_q;
   assign sel_vld_o  = sel_vld_q;
   assign hilo_rd_o  = hilo_rd_q;
   assign hilo_vld_o = hilo_vld_q;
   assign busy_o     = mdu_busy;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Testbench for alu_ctrl_mdu: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_ctrl_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         valid_i = 1'b0;
   logic         flush_i = 1'b0;
   logic [1:0]   alu_op_i = 2'b00;
   logic [5:0]   funct_i = 6'b0;
   logic [W-1:0] rs_val_i = '0;
   logic [W-1:0] rt_val_i = '0;
   logic         stall_o, sel_vld_o, hilo_vld_o, busy_o;
   logic [3:0]   alu_sel_o;
   logic [W-1:0] hilo_rd_o, hi_o, lo_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   alu_ctrl_mdu #(.WIDTH(W), .OPW(4), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid_i),
      .flush_i    (flush_i),
      .alu_op_i   (alu_op_i),
      .funct_i    (funct_i),
      .rs_val_i   (rs_val_i),
      .rt_val_i   (rt_val_i),
      .stall_o    (stall_o),
      .alu_sel_o  (alu_sel_o),
      .sel_vld_o  (sel_vld_o),
      .hilo_rd_o  (hilo_rd_o),
      .hilo_vld_o (hilo_vld_o),
      .busy_o     (busy_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b1111;
      case (fn)
         6'h20:   return 4'b0010;
         6'h22:   return 4'b0110;
         6'h2A:   return 4'b0111;
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         6'h27:   return 4'b1100;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic bit ref_cls(input logic [1:0] op, input logic [5:0] fn);
      return (op == 2'b10) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13});
   endfunction

   task automatic ref_mdu(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (fn)
         6'h18: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         6'h19: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         6'h1A: begin
            if (b == 0) begin
               // quotient magnitude all ones, negated when the dividend is negative
               lo = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
               hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'h0;
            end else begin
               q = sa / sb;
               r = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end
         end
         default: begin
            if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endtask

   logic [W-1:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_hilo_rd;
   logic [3:0]   m_sel;
   logic         m_sel_vld, m_hilo_vld;
   int           m_busy;
   bit           mdl_stall, mdl_acc;

   // Model advances on each clock edge from the inputs presented before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0; m_hilo_rd = '0;
         m_sel = 4'hF; m_sel_vld = 1'b0; m_hilo_vld = 1'b0; m_busy = 0;
      end else begin
         mdl_stall = valid_i && (m_busy > 0) && ref_cls(alu_op_i, funct_i);
         mdl_acc   = valid_i && !mdl_stall && !flush_i;
         if (m_busy > 0) begin
            if (flush_i) m_busy = 0;
            else begin
               m_busy--;
               if (m_busy == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
            end
         end
         m_sel_vld  = mdl_acc;
         m_hilo_vld = 1'b0;
         if (mdl_acc) begin
            m_sel = ref_sel(alu_op_i, funct_i);
            if (alu_op_i == 2'b10) begin
               case (funct_i)
                  6'h18, 6'h19, 6'h1A, 6'h1B: begin
                     ref_mdu(funct_i, rs_val_i, rt_val_i, m_pend_hi, m_pend_lo);
                     m_busy = W + 1;
                  end
                  6'h10: begin m_hilo_rd = m_hi; m_hilo_vld = 1'b1; end
                  6'h12: begin m_hilo_rd = m_lo; m_hilo_vld = 1'b1; end
                  6'h11: m_hi = rs_val_i;
                  6'h13: m_lo = rs_val_i;
                  default: ;
               endcase
            end
         end
      end
   end

   // Compare process: every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("alu_sel_o",  alu_sel_o,  m_sel);
         check("sel_vld_o",  sel_vld_o,  m_sel_vld);
         check("hilo_rd_o",  hilo_rd_o,  m_hilo_rd);
         check("hilo_vld_o", hilo_vld_o, m_hilo_vld);
         check("busy_o",     busy_o,     m_busy > 0);
         check("hi_o",       hi_o,       m_hi);
         check("lo_o",       lo_o,       m_lo);
         check("stall_o",    stall_o,    valid_i && (m_busy > 0) && ref_cls(alu_op_i, funct_i));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      valid_i = v; flush_i = fl; alu_op_i = op; funct_i = fn; rs_val_i = a; rt_val_i = b;
      @(posedge clk); #2;
      valid_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy_o && cyc < 200) begin @(posedge clk); #2; cyc++; end
      check("wait_idle_bound", busy_o, 1'b0);
   endtask

   function automatic logic [W-1:0] pick_opd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         4:       return -32'($urandom_range(1, 15));
         default: return $urandom();
      endcase
   endfunction

   logic [5:0] t1_fn  [8] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h27, 6'h00, 6'h3F};
   logic [3:0] t1_sel [8] = '{4'h2, 4'h6, 4'h7, 4'h0, 4'h1, 4'hC, 4'hF, 4'hF};
   logic [5:0] pool   [16] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h27, 6'h00, 6'h3F,
                               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13};

   initial begin
      int cyc;
      int stalls;
      #1 rst_n = 1'b0;
      #1;
      check("rst_alu_sel", alu_sel_o, 4'hF);
      check("rst_sel_vld", sel_vld_o, 1'b0);
      check("rst_busy",    busy_o,    1'b0);
      check("rst_hi",      hi_o,      32'h0);
      check("rst_lo",      lo_o,      32'h0);
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      idle(1);

      // ALUOp 10 decode table, then the fixed ALUOps
      for (int i = 0; i < 8; i++) begin
         issue(1, 0, 2'b10, t1_fn[i], '0, '0);
         check("sel_rtype", alu_sel_o, t1_sel[i]);
         check("sel_vld_rtype", sel_vld_o, 1'b1);
      end
      issue(1, 0, 2'b00, 6'h2A, '0, '0); check("sel_op00", alu_sel_o, 4'h2);
      issue(1, 0, 2'b01, 6'h20, '0, '0); check("sel_op01", alu_sel_o, 4'h6);
      issue(1, 0, 2'b11, 6'h20, '0, '0); check("sel_op11", alu_sel_o, 4'hF);
      issue(1, 0, 2'b10, 6'h18, '0, '0); check("sel_mult", alu_sel_o, 4'hF);
      wait_idle(cyc);

      // MULT / MULTU
      issue(1, 0, 2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7);
      wait_idle(cyc);
      check("mult_busy_cycles", cyc, 33);
      check("mult_hi", hi_o, 32'hFFFF_FFFF);
      check("mult_lo", lo_o, 32'hFFFF_FFEB);
      issue(1, 0, 2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2);
      wait_idle(cyc);
      check("multu_hi", hi_o, 32'h1);
      check("multu_lo", lo_o, 32'hFFFF_FFFE);

      // DIV / DIVU incl. divide by zero and MIN / -1
      issue(1, 0, 2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2);
      wait_idle(cyc);
      check("div_lo", lo_o, 32'hFFFF_FFFD);
      check("div_hi", hi_o, 32'hFFFF_FFFF);
      issue(1, 0, 2'b10, 6'h1B, 32'd5, 32'd0);
      wait_idle(cyc);
      check("divu0_lo", lo_o, 32'hFFFF_FFFF);
      check("divu0_hi", hi_o, 32'd5);
      issue(1, 0, 2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cyc);
      check("divmin_lo", lo_o, 32'h8000_0000);
      check("divmin_hi", hi_o, 32'h0);

      // MFLO stalled behind MULT; ADD mid-op goes through
      issue(1, 0, 2'b10, 6'h18, 32'd5, 32'd6);
      valid_i = 1'b1; alu_op_i = 2'b10; funct_i = 6'h20;
      #1 check("add_no_stall", stall_o, 1'b0);
      @(posedge clk); #2;
      check("add_sel_midop", alu_sel_o, 4'h2);
      valid_i = 1'b0;
      idle(1);
      valid_i = 1'b1; alu_op_i = 2'b10; funct_i = 6'h12;
      #1;
      stalls = 0;
      while (stall_o && stalls < 100) begin @(posedge clk); #1; stalls++; end
      check("mf_stall_cycles", stalls, 31);
      check("mf_after_busy", busy_o, 1'b0);
      @(posedge clk); #2;
      valid_i = 1'b0;
      check("mflo_vld", hilo_vld_o, 1'b1);
      check("mflo_val", hilo_rd_o, 32'd30);

      // flush at iteration 10 of DIV; flush beats a start
      issue(1, 0, 2'b10, 6'h11, 32'h1234_5678, '0);
      issue(1, 0, 2'b10, 6'h13, 32'h9ABC_DEF0, '0);
      issue(1, 0, 2'b10, 6'h1A, 32'd100, 32'd7);
      idle(9);
      issue(0, 1, 2'b00, 6'h00, '0, '0);
      check("flush_busy", busy_o, 1'b0);
      idle(40);
      check("flush_hi", hi_o, 32'h1234_5678);
      check("flush_lo", lo_o, 32'h9ABC_DEF0);
      issue(1, 1, 2'b10, 6'h18, 32'd3, 32'd3);
      check("flush_start_busy", busy_o, 1'b0);
      check("flush_start_vld", sel_vld_o, 1'b0);
      issue(1, 0, 2'b10, 6'h11, 32'hAAAA_5555, '0);
      issue(1, 0, 2'b10, 6'h10, '0, '0);
      check("mfhi_val", hilo_rd_o, 32'hAAAA_5555);
      check("mfhi_vld", hilo_vld_o, 1'b1);

      // asynchronous reset mid-MULT
      issue(1, 0, 2'b10, 6'h11, 32'hDEAD_0000, '0);
      issue(1, 0, 2'b10, 6'h18, 32'd9, 32'd9);
      idle(5);
      #1 rst_n = 1'b0;
      #1;
      check("arst_alu_sel", alu_sel_o, 4'hF);
      check("arst_sel_vld", sel_vld_o, 1'b0);
      check("arst_busy",    busy_o,    1'b0);
      check("arst_hi",      hi_o,      32'h0);
      check("arst_lo",      lo_o,      32'h0);
      check("arst_hilo_vld", hilo_vld_o, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      issue(1, 0, 2'b10, 6'h10, '0, '0);
      check("arst_mfhi_val", hilo_rd_o, 32'h0);
      check("arst_mfhi_vld", hilo_vld_o, 1'b1);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 2500; i++) begin
         valid_i  = ($urandom_range(0, 3) != 0);
         flush_i  = ($urandom_range(0, 29) == 0);
         alu_op_i = ($urandom_range(0, 7) < 5) ? 2'b10 : 2'($urandom_range(0, 3));
         funct_i  = pool[$urandom_range(0, 15)];
         rs_val_i = pick_opd();
         rt_val_i = pick_opd();
         @(posedge clk); #2;
      end
      valid_i = 1'b0; flush_i = 1'b0;
      idle(40);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
